score_bcd_to_bin: RTL and testbench

- Sequential decimal-to-binary converter for the score path.
- Takes a 5-digit BCD score (digit entry, stored high-score table, or UART/debug loader) and produces the 17-bit binary score.
- The binary result feeds the score register and comparators.
- Uses an iterative multiply-by-10-and-accumulate datapath, one digit per clock, with a start/busy/done handshake.

---
 rtl/score_bcd_to_bin.sv | 94 +++++++++
 tb/tb_score_bcd_to_bin.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/score_bcd_to_bin.sv
// Iterative BCD-to-binary score converter: one decimal digit per clock,
// most significant first, with a start/busy/done handshake and an invalid-digit error path.
module score_bcd_to_bin #(
   parameter int NUM_DIGITS = 5,
   parameter int WIDTH      = 17
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH-1:0]        score,
   output logic                    err
);

   localparam int DW = 4*NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS+1);

   typedef enum logic [1:0] {IDLE, CONV, FAIL} state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     sreg;
   logic [WIDTH-1:0]  acc, acc_nxt;
   logic [CW-1:0]     cnt;
   logic [WIDTH+3:0]  acc_ext, acc_mul;
   logic [NUM_DIGITS-1:0] dig_bad;
   logic              last;

   // A nibble is out of BCD range when it is 1010..1111.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_chk
      assign dig_bad[i] = digits[4*i+3] & (digits[4*i+2] | digits[4*i+1]);
   end

   assign acc_ext = {4'b0000, acc};
   assign acc_mul = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, sreg[DW-1 -: 4]};
   assign acc_nxt = acc_mul[WIDTH-1:0];
   assign last    = (cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (|dig_bad) ? FAIL : CONV;
         CONV:    if (last)  state_nxt = IDLE;
         FAIL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         score <= '0;
         err   <= 1'b0;
         acc   <= '0;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sreg <= digits;
               acc  <= '0;
               cnt  <= CW'(NUM_DIGITS);
            end
            CONV: begin
               acc  <= acc_nxt;
               sreg <= {sreg[DW-5:0], 4'b0000};
               cnt  <= cnt - CW'(1);
               // Final digit: publish the accumulator result on the same edge.
               if (last) begin
                  score <= acc_nxt;
                  err   <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FAIL: begin
               score <= '0;
               err   <= 1'b1;
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_score_bcd_to_bin.sv
// Randomized scoreboard bench for score_bcd_to_bin: a decimal reference model predicts
// each accepted conversion, and a monitor checks every done pulse plus busy/hold behaviour.
module tb_score_bcd_to_bin;

   localparam int ND = 5;
   localparam int W  = 17;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [4*ND-1:0] digits = '0;
   logic          busy, done, err;
   logic [W-1:0]  score;

   score_bcd_to_bin #(.NUM_DIGITS(ND), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .digits(digits),
      .busy(busy), .done(done), .score(score), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { int sc; bit er; int de; } exp_t;
   exp_t q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_edge = 0;
   int next_free = 0;
   int last_sc = 0;
   bit last_er = 1'b0;

   function automatic void ref_conv(input logic [4*ND-1:0] d, output int sc, output bit bad);
      int p;
      logic [3:0] dg;
      sc = 0; bad = 1'b0; p = 1;
      for (int i = 0; i < ND; i++) begin
         dg = d[4*i +: 4];
         if (dg > 9) bad = 1'b1;
         sc += int'(dg) * p;
         p *= 10;
      end
      if (bad) sc = 0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, n_edge);
      end
   endtask

   // Reference model: decides acceptance from its own notion of occupancy.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         next_free = 0;
         n_edge = 0;
      end else begin
         int sc; bit bad; exp_t e;
         n_edge++;
         if (start && n_edge >= next_free) begin
            ref_conv(digits, sc, bad);
            e.sc = sc; e.er = bad;
            e.de = n_edge + (bad ? 1 : ND);
            q.push_back(e);
            next_free = e.de + 1;
         end
      end
   end

   // Monitor: compare on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_sc = 0; last_er = 1'b0;
         check("reset_busy", int'(busy), 0);
         check("reset_done", int'(done), 0);
         check("reset_score", int'(score), 0);
         check("reset_err", int'(err), 0);
      end else begin
         check("busy", int'(busy), int'(n_edge < next_free - 1));
         if (done) begin
            if (q.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("done_timing", n_edge, e.de);
               check("score", int'(score), e.sc);
               check("err", int'(err), int'(e.er));
               last_sc = e.sc; last_er = e.er;
            end
         end else begin
            check("score_hold", int'(score), last_sc);
            check("err_hold", int'(err), int'(last_er));
            if (q.size() != 0 && n_edge > q[0].de) check("missing_done", n_edge, q[0].de);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic conv(input logic [4*ND-1:0] d, input int wait_cyc);
      @(negedge clk);
      start = 1'b1; digits = d;
      @(negedge clk);
      start = 1'b0;
      idle(wait_cyc);
   endtask

   function automatic logic [4*ND-1:0] rand_digits();
      logic [4*ND-1:0] d;
      for (int i = 0; i < ND; i++)
         d[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      return d;
   endfunction

   initial begin
      idle(2);
      rst_n = 1'b1;
      idle(1);

      conv(20'h12345, 7);
      conv(20'h99999, 7);
      conv(20'h00000, 7);
      conv(20'h12A45, 3);
      conv(20'h00007, 7);

      // Start held high: back-to-back conversions of 42.
      @(negedge clk);
      start = 1'b1; digits = 20'h00042;
      idle(20);
      start = 1'b0;
      idle(7);

      // Start pulses and digit changes while busy must be ignored.
      conv(20'h11111, 0);
      start = 1'b1; digits = 20'h99999;
      idle(2);
      start = 1'b0; digits = 20'h0A0A0;
      idle(6);

      // Asynchronous reset in the middle of a conversion.
      conv(20'h54321, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", int'(busy), 0);
      check("async_score", int'(score), 0);
      check("async_done", int'(done), 0);
      idle(2);
      rst_n = 1'b1;
      conv(20'h54321, 7);

      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         start  = ($urandom_range(0, 3) == 0);
         digits = rand_digits();
      end
      @(negedge clk);
      start = 1'b0;
      idle(10);
      check("drain", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
